// File: rtl/sram_arb_ctrl_pkg.sv
// Shared constants for the arbitrated SRAM controller.
// Holds the init/ready FSM encodings and the byte-lane helper.
// Everything here is compile-time only; no logic lives in the package.
package sram_arb_ctrl_pkg;

  // Controller FSM: zero-fill sweep, then open for requestor traffic.
  localparam logic [0:0] S_INIT  = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  // Bits per byte lane of the write mask.
  localparam int BYTE_W = 8;

  // Number of byte lanes (mask bits) in a word of the given width.
  function automatic int num_bytes(input int data_width);
    return data_width / BYTE_W;
  endfunction

endpackage

// File: rtl/sram.sv
// Single-port synchronous SRAM macro view: active-low select/write, byte mask.
// Read data registered one cycle after select (plus DELAY extra stages).
// Output holds its value in any cycle without a read.
module sram #(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 13,
  parameter int    DELAY      = 0,
  parameter int    IZERO      = 0,
  parameter string IFILE      = ""
) (
  input  logic                    clk_i,
  input  logic                    csb,
  input  logic                    web,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wmask,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;

  // Array access: masked byte writes, or a registered read that updates rd_q only on reads.
  always_ff @(posedge clk_i) begin
    if (!csb) begin
      if (!web) begin
        for (int b = 0; b < NB; b++) begin
          if (wmask[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end else begin
        rd_q <= mem[addr];
      end
    end
  end

  if (DELAY == 0) begin : g_nodelay
    assign rdata = rd_q;
  end else begin : g_delay
    logic [DATA_WIDTH-1:0] pipe_q [DELAY];

    // Extra output pipeline stages for slow macro corners.
    always_ff @(posedge clk_i) begin
      pipe_q[0] <= rd_q;
      for (int i = 1; i < DELAY; i++) pipe_q[i] <= pipe_q[i-1];
    end

    assign rdata = pipe_q[DELAY-1];
  end

  // Power-on image (zeroed or file-loaded) is applied by the macro compile
  // flow, not by this behavioural view; contents start undefined here.
  if (IZERO != 0 || IFILE != "") begin : g_preload
  end

endmodule

// File: rtl/sram_arb_ctrl_arb.sv
// Round-robin arbiter: one-hot grant among requesting ports.
// Grant is combinational in the request cycle; pointer updates on the clock edge.
// When disabled no grant is issued and the pointer holds.
module rr_arbiter #(
  parameter int NUM_PORTS = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W:0]   scan;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Scan ports starting at the pointer; first requester wins, pointer moves past it.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    scan  = '0;
    idx   = '0;
    found = 1'b0;
    if (en_i) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        scan = {1'b0, ptr_q} + (PTR_W+1)'(i);
        if (scan >= (PTR_W+1)'(NUM_PORTS)) scan = scan - (PTR_W+1)'(NUM_PORTS);
        idx = scan[PTR_W-1:0];
        if (!found && req_i[idx]) begin
          found      = 1'b1;
          gnt_o[idx] = 1'b1;
          ptr_d      = (idx == PTR_W'(NUM_PORTS-1)) ? '0 : idx + PTR_W'(1);
        end
      end
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Multi-port round-robin front end for one single-port SRAM macro, with optional zero-fill.
// Grant same cycle as request; read data and rvalid one cycle after a granted read.
// No grants while initialising; losing ports simply hold their request.
module sram_arb_ctrl
  import sram_arb_ctrl_pkg::*;
#(
  parameter int    NUM_PORTS  = 2,
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 13,
  parameter int    INIT_ZERO  = 0,
  parameter string IFILE      = ""
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NUM_PORTS-1:0]                      req_i,
  input  logic [NUM_PORTS-1:0]                      we_i,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]      addr_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]      wdata_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/BYTE_W-1:0] wmask_i,
  output logic [NUM_PORTS-1:0]                      gnt_o,
  output logic [NUM_PORTS-1:0]                      rvalid_o,
  output logic [DATA_WIDTH-1:0]                     rdata_o,
  output logic                                      init_done_o
);

  localparam int NB = num_bytes(DATA_WIDTH);
  // Last word address; the counter carries one spare bit so it never wraps.
  localparam logic [ADDR_WIDTH:0] INIT_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};

  logic [0:0]            state_q;
  logic [ADDR_WIDTH:0]   init_cnt_q;
  logic                  init_wr;
  logic                  gnt_any;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [NB-1:0]         sel_wmask;
  logic                  mem_csb;
  logic                  mem_web;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NB-1:0]         mem_wmask;
  logic [NUM_PORTS-1:0]  rvalid_q;

  assign init_done_o = (state_q == S_READY);
  assign init_wr     = (state_q == S_INIT) && (INIT_ZERO != 0);

  // Init FSM: without zero-fill, leave INIT on the first edge after reset;
  // with zero-fill, sweep every address once and stop at the last one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
    end else if (state_q == S_INIT) begin
      if (INIT_ZERO == 0 || init_cnt_q == INIT_LAST) state_q <= S_READY;
      else                                          init_cnt_q <= init_cnt_q + (ADDR_WIDTH+1)'(1);
    end
  end

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (init_done_o),
    .req_i  (req_i),
    .gnt_o  (gnt_o)
  );

  // Steer the granted port's command onto the macro port.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wmask = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt_o[p]) begin
        sel_we    = we_i[p];
        sel_addr  = addr_i[p];
        sel_wdata = wdata_i[p];
        sel_wmask = wmask_i[p];
      end
    end
  end

  assign gnt_any = |gnt_o;

  // Grants are held off during init, so init writes and port traffic never collide.
  assign mem_csb   = ~(init_wr | gnt_any);
  assign mem_web   = init_wr ? 1'b0 : ~sel_we;
  assign mem_addr  = init_wr ? init_cnt_q[ADDR_WIDTH-1:0] : sel_addr;
  assign mem_wdata = init_wr ? '0 : sel_wdata;
  assign mem_wmask = init_wr ? '1 : sel_wmask;

  sram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DELAY      (0),
    .IZERO      (0),
    .IFILE      (IFILE)
  ) u_sram (
    .clk_i (clk_i),
    .csb   (mem_csb),
    .web   (mem_web),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .wmask (mem_wmask),
    .rdata (rdata_o)
  );

  // Read-return tag: marks the port whose granted read lands on rdata_o next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rvalid_q <= '0;
    else         rvalid_q <= gnt_o & req_i & ~we_i;
  end

  assign rvalid_o = rvalid_q;

endmodule

// File: doc/sram_arb_ctrl.md
SRAM_ARB_CTRL -- requirements
Module: sram_arb_ctrl

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of requestor ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width in bits (multiple of 8).
REQ-003 SHALL have parameter ADDR_WIDTH, default 13, word address width; depth = 2**ADDR_WIDTH.
REQ-004 SHALL have parameter INIT_ZERO, default 0; 1 = zero-fill the whole array after reset.
REQ-005 SHALL have parameter IFILE, default "", preload file passed to the macro.
REQ-006 SHALL have port clk_i  in  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have port req_i  in  NUM_PORTS  per-port request.
REQ-009 SHALL have port we_i  in  NUM_PORTS  per-port write enable (1 = write).
REQ-010 SHALL have port addr_i  in  NUM_PORTS x ADDR_WIDTH  per-port word address.
REQ-011 SHALL have port wdata_i  in  NUM_PORTS x DATA_WIDTH  per-port write data.
REQ-012 SHALL have port wmask_i  in  NUM_PORTS x DATA_WIDTH/8  per-port byte mask.
REQ-013 SHALL have port gnt_o  out  NUM_PORTS  one-hot grant, combinational, same cycle as req.
REQ-014 SHALL have port rvalid_o  out  NUM_PORTS  read data valid for that port.
REQ-015 SHALL have port rdata_o  out  DATA_WIDTH  read data, shared by all ports.
REQ-016 SHALL have port init_done_o  out  1  array ready for traffic.

Function
REQ-017 SHALL grant at most one port per cycle; transfer occurs when req_i[p] & gnt_o[p].
REQ-018 SHALL arbitrate round-robin; priority pointer moves to the port after the granted one, unchanged when nothing granted.
REQ-019 SHALL hold gnt_o all-zero while init_done_o is 0.
REQ-020 SHALL drive macro enable (csb low) only in cycles with a granted request or an init write.
REQ-021 SHALL apply wmask_i per byte on writes; mask 0 write leaves the word unchanged.
REQ-022 SHALL assert rvalid_o[p] exactly one cycle after a granted read from port p, with rdata_o valid that cycle.
REQ-023 SHALL NOT assert rvalid_o for writes.
REQ-024 SHALL sustain back-to-back transfers, one per cycle, across any ports.
REQ-025 SHALL return new data for a read granted the cycle after a write to the same address.
REQ-026 SHALL implement FSM INIT -> READY when INIT_ZERO=1: INIT writes zero, full mask, to addresses 0..depth-1 one per cycle; after last address, enter READY.
REQ-027 SHALL start in READY with init_done_o=1 the first cycle after reset release when INIT_ZERO=0.
REQ-028 SHALL keep init counter ADDR_WIDTH+1 bits wide; terminal at depth-1, no wrap.
REQ-029 SHALL keep rdata_o stable between reads (no macro enable -> output held).

Reset
REQ-030 SHALL on rst_ni low: gnt_o=0, rvalid_o=0, init_done_o=0, RR pointer=0, init counter=0, FSM=INIT (INIT_ZERO=1) or READY-pending.
REQ-031 SHALL abort an in-flight read on reset: no rvalid_o after release.
REQ-032 SHALL restart the zero-fill from address 0 if reset asserts mid-init.
REQ-033 SHALL not guarantee array contents after reset unless INIT_ZERO=1.

Structure
REQ-034 SHALL place FSM state enum (S_INIT, S_READY) and byte-count helper constant in package sram_arb_ctrl_pkg.
REQ-035 SHALL instantiate the team sram macro (DELAY 0, IZERO 0, IFILE passed through) as the storage.
REQ-036 SHALL implement arbitration in one sub-module rr_arbiter, parametrised by NUM_PORTS.

Verification
REQ-037 Write port0 addr 0x010 data 0xDEADBEEF mask 0xF, then read port1 addr 0x010 -> rvalid_o=2'b10 next cycle, rdata_o=0xDEADBEEF.
REQ-038 Both ports req every cycle for 4 cycles -> gnt_o 01,10,01,10.
REQ-039 Write 0x11223344 mask 0xF, then 0xAABBCCDD mask 0x5 same addr, read -> 0x11BB33DD.
REQ-040 INIT_ZERO=1, ADDR_WIDTH=4 -> init_done_o rises after 16 cycles; read any addr -> 0.
REQ-041 Reset pulse at init address 7 -> fill restarts at 0, init_done_o after full 16 more cycles.
REQ-042 Read granted, rst_ni low next cycle -> rvalid_o stays 0.
